// File: rtl/regfl_pkg.sv
// Shared definitions for the 2-read/1-write register file: defaults, width helper and
// the read-response record used by consumers.
package regfl_pkg;

  localparam int unsigned DataWDef = 8;
  localparam int unsigned DepthDef = 4;

  // Ceiling log2, never less than 1 so an address bus always exists.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

  typedef struct packed {
    logic [DataWDef-1:0] data;
    logic                vld;
    logic                uninit;
  } rd_resp_t;

endpackage

// File: rtl/regfl_rdport.sv
// One registered read port: range check, write-first bypass and uninitialised-entry flag.
// Honours REGFL_ZERO_REG_EN (entry 0 reads as a constant zero).
module regfl_rdport
  import regfl_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned DEPTH  = DepthDef,
  localparam int unsigned ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_e,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_e,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] mem [DEPTH],
  input  logic [DEPTH-1:0]  written,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld,
  output logic              rd_uninit,
  output logic              rd_oor
);

  logic              rd_in, wr_in, rd_zero, byp;
  logic [DATA_W-1:0] data_d, data_q;
  logic              uninit_d, uninit_q, vld_q;

  assign rd_in  = 32'(rd_addr) < DEPTH;
  assign wr_in  = 32'(wr_addr) < DEPTH;
  assign rd_oor = rd_e & ~rd_in;

`ifdef REGFL_ZERO_REG_EN
  assign rd_zero = (rd_addr == '0);
`else
  assign rd_zero = 1'b0;
`endif

  assign byp = wr_e & wr_in & (wr_addr == rd_addr) & ~rd_zero;

  always_comb begin
    data_d   = data_q;
    uninit_d = uninit_q;
    if (rd_e) begin
      if (!rd_in || rd_zero) begin
        data_d   = '0;
        uninit_d = 1'b0;
      end else if (byp) begin
        data_d   = wr_data;
        uninit_d = 1'b0;
      end else begin
        data_d   = mem[rd_addr];
        uninit_d = ~written[rd_addr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      uninit_q <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      data_q   <= data_d;
      uninit_q <= uninit_d;
      vld_q    <= rd_e;
    end
  end

  assign rd_data   = data_q;
  assign rd_vld    = vld_q;
  assign rd_uninit = uninit_q;

endmodule

// File: rtl/regfl_2r1w.sv
// DEPTH x DATA_W register file, one write port and two registered read ports with bypass.
// Define REGFL_ZERO_REG_EN to hardwire entry 0 to zero.
module regfl_2r1w
  import regfl_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned DEPTH  = DepthDef,
  localparam int unsigned ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_e,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_e0,
  input  logic [ADDR_W-1:0] rd_addr0,
  output logic [DATA_W-1:0] rd_data0,
  output logic              rd_vld0,
  output logic              rd_uninit0,
  input  logic              rd_e1,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_vld1,
  output logic              rd_uninit1,
  output logic              addr_err
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  written_q;
  logic              wr_in, wr_ok, oor0, oor1, addr_err_q;

  assign wr_in = 32'(wr_addr) < DEPTH;

`ifdef REGFL_ZERO_REG_EN
  assign wr_ok = wr_e & wr_in & (wr_addr != '0);
`else
  assign wr_ok = wr_e & wr_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      written_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem_q[wr_addr]     <= wr_data;
        written_q[wr_addr] <= 1'b1;
      end
      addr_err_q <= (wr_e & ~wr_in) | oor0 | oor1;
    end
  end

  assign addr_err = addr_err_q;

  regfl_rdport #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rdport0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_e      (rd_e0),
    .rd_addr   (rd_addr0),
    .wr_e      (wr_e),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mem       (mem_q),
    .written   (written_q),
    .rd_data   (rd_data0),
    .rd_vld    (rd_vld0),
    .rd_uninit (rd_uninit0),
    .rd_oor    (oor0)
  );

  regfl_rdport #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rdport1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_e      (rd_e1),
    .rd_addr   (rd_addr1),
    .wr_e      (wr_e),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mem       (mem_q),
    .written   (written_q),
    .rd_data   (rd_data1),
    .rd_vld    (rd_vld1),
    .rd_uninit (rd_uninit1),
    .rd_oor    (oor1)
  );

endmodule

// File: tb/tb_regfl_2r1w.sv
// Scoreboard bench for regfl_2r1w with DEPTH=5 so out-of-range addresses are reachable.
module tb_regfl_2r1w;
  import regfl_pkg::*;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 5;
`ifdef REGFL_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_e;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_e0, rd_e1;
  logic [2:0] rd_addr0, rd_addr1;
  logic [7:0] rd_data0, rd_data1;
  logic       rd_vld0, rd_vld1, rd_uninit0, rd_uninit1, addr_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem_m [DEPTH];
  logic       wr_m  [DEPTH];
  rd_resp_t   last0, last1;
  rd_resp_t   exp_q0 [$];
  rd_resp_t   exp_q1 [$];
  logic       err_q  [$];

  always #5 clk = ~clk;

  regfl_2r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_e       (wr_e),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_e0      (rd_e0),
    .rd_addr0   (rd_addr0),
    .rd_data0   (rd_data0),
    .rd_vld0    (rd_vld0),
    .rd_uninit0 (rd_uninit0),
    .rd_e1      (rd_e1),
    .rd_addr1   (rd_addr1),
    .rd_data1   (rd_data1),
    .rd_vld1    (rd_vld1),
    .rd_uninit1 (rd_uninit1),
    .addr_err   (addr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic rd_resp_t model_rd(input logic e, input logic [2:0] a, input rd_resp_t prev,
                                        input logic we, input logic [2:0] wa, input logic [7:0] wd);
    rd_resp_t r;
    r     = prev;
    r.vld = e;
    if (e) begin
      if (32'(a) >= DEPTH || (ZeroReg && a == 3'd0)) begin
        r.data   = '0;
        r.uninit = 1'b0;
      end else if (we && wa == a) begin
        r.data   = wd;
        r.uninit = 1'b0;
      end else begin
        r.data   = mem_m[a];
        r.uninit = ~wr_m[a];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_m[i] = '0;
      wr_m[i]  = 1'b0;
    end
    last0 = '0;
    last1 = '0;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                      input logic e0, input logic [2:0] a0, input logic e1, input logic [2:0] a1);
    rd_resp_t got;
    wr_e = we; wr_addr = wa; wr_data = wd;
    rd_e0 = e0; rd_addr0 = a0; rd_e1 = e1; rd_addr1 = a1;
    last0 = model_rd(e0, a0, last0, we, wa, wd);
    last1 = model_rd(e1, a1, last1, we, wa, wd);
    exp_q0.push_back(last0);
    exp_q1.push_back(last1);
    err_q.push_back((we && 32'(wa) >= DEPTH) || (e0 && 32'(a0) >= DEPTH) ||
                    (e1 && 32'(a1) >= DEPTH));
    @(posedge clk);
    if (we && 32'(wa) < DEPTH && !(ZeroReg && wa == 3'd0)) begin
      mem_m[wa] = wd;
      wr_m[wa]  = 1'b1;
    end
    @(negedge clk);
    got = exp_q0.pop_front();
    check("data0", rd_data0, got.data);
    check("vld0", rd_vld0, got.vld);
    check("uninit0", rd_uninit0, got.uninit);
    got = exp_q1.pop_front();
    check("data1", rd_data1, got.data);
    check("vld1", rd_vld1, got.vld);
    check("uninit1", rd_uninit1, got.uninit);
    check("addr_err", addr_err, err_q.pop_front());
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  task automatic dump();
    for (int i = 0; i < int'(DEPTH); i++) step(1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b1, 3'(i));
  endtask

  initial begin
    rst_n = 1'b0;
    wr_e = 1'b0; wr_addr = '0; wr_data = '0;
    rd_e0 = 1'b0; rd_addr0 = '0; rd_e1 = 1'b0; rd_addr1 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_data0", rd_data0, 8'h00);
    check("rst_vld0", rd_vld0, 1'b0);
    check("rst_uninit0", rd_uninit0, 1'b0);
    check("rst_data1", rd_data1, 8'h00);
    check("rst_vld1", rd_vld1, 1'b0);
    check("rst_addr_err", addr_err, 1'b0);
    rst_n = 1'b1;

    // Read of an unwritten entry reports uninitialised zero.
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 3'd0);
    check("uninit_direct", rd_uninit0, 1'b1);
    // Write then read on both ports.
    step(1'b1, 3'd1, 8'hA5, 1'b0, 3'd0, 1'b0, 3'd0);
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b1, 3'd1);
    check("wr_rd_direct", rd_data1, 8'hA5);
    // Bypass: old value 0x11, same-edge write of 0x3C.
    step(1'b1, 3'd3, 8'h11, 1'b0, 3'd0, 1'b0, 3'd0);
    step(1'b1, 3'd3, 8'h3C, 1'b1, 3'd1, 1'b1, 3'd3);
    check("bypass_direct", rd_data1, 8'h3C);
    // Both ports bypassing together.
    step(1'b1, 3'd2, 8'h5A, 1'b1, 3'd2, 1'b1, 3'd2);
    // Out-of-range write and read, then addr_err must drop.
    step(1'b1, 3'd6, 8'hFF, 1'b1, 3'd7, 1'b0, 3'd0);
    check("oor_err_direct", addr_err, 1'b1);
    idle();
    dump();
    // Address 0 write/read (behaviour depends on REGFL_ZERO_REG_EN).
    step(1'b1, 3'd0, 8'h77, 1'b0, 3'd0, 1'b0, 3'd0);
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd0);
    check("zero_reg_direct", rd_data0, ZeroReg ? 8'h00 : 8'h77);
    // Same-address bypass at entry 0.
    step(1'b1, 3'd0, 8'h42, 1'b1, 3'd0, 1'b0, 3'd0);

    for (int n = 0; n < 300; n++) begin
      step(1'($urandom), 3'($urandom_range(0, 7)), 8'($urandom),
           1'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 3'($urandom_range(0, 7)));
    end
    dump();

    // Reset dropped before the edge that would capture a pending read.
    wr_e = 1'b1; wr_addr = 3'd4; wr_data = 8'hEE;
    rd_e0 = 1'b1; rd_addr0 = 3'd1; rd_e1 = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_vld0", rd_vld0, 1'b0);
    check("midrst_data0", rd_data0, 8'h00);
    check("midrst_addr_err", addr_err, 1'b0);
    model_reset();
    rst_n = 1'b1;
    dump();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
